// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter
//   Shares one bank of NUM_REGS registers between NUM_REQ write requesters.
//   Round-robin arbitration with an optional burst lock, then one registered
//   write stage that drives the shared D bus and the per-register active-low
//   load strobes. One write retires per clock.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   req_valid   per-requester write request
//   req_lock    requester wants to keep the grant after this transfer
//   req_addr    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data    packed data, requester i at [i*WIDTH +: WIDTH]
//   req_ready   one-hot grant (combinational)
//   reg_d       shared D bus to the bank (registered)
//   reg_load_n  active-low load strobe per register (registered)
//   grant_id    requester whose write is on reg_d this cycle
//   addr_err    one-cycle pulse for an accepted write to addr >= NUM_REGS
//   busy        high while LOCKED or while a load strobe is active
//   fsm_state   debug view of the arbiter FSM (0 = IDLE, 1 = LOCKED)
//
// Handshake: a transfer happens on any rising edge where req_valid[i] and
// req_ready[i] are both 1. req_ready depends only on req_valid and the
// registered state, so it is never withdrawn within a cycle unless
// req_valid changes. Requesters hold addr/data stable while valid && !ready.
module regbank_write_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [WIDTH-1:0]          reg_d,
  output logic [NUM_REGS-1:0]       reg_load_n,
  output logic [2:0]                grant_id,
  output logic                      addr_err,
  output logic                      busy,
  output logic                      fsm_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   owner;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [WIDTH-1:0]   data_arr [NUM_REQ];

  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic               addr_ok;
  logic [NUM_REGS-1:0] load_n_next;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin search starting one past the last IDLE winner.
  always_comb begin
    logic [IDX_W-1:0] cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (xfer && req_lock[sel_idx]) state_next = LOCKED;
      end
      LOCKED: begin
        // Owner dropping valid releases the lock with no grant that cycle.
        if (!req_valid[owner])                state_next = IDLE;
        else if (xfer && !req_lock[owner])    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs (grant). Gated by reset so no grant is seen while it is low.
  always_comb begin
    req_ready = '0;
    sel_idx   = rr_idx;
    if (reset) begin
      case (state)
        IDLE: begin
          if (rr_found) req_ready[rr_idx] = 1'b1;
        end
        LOCKED: begin
          sel_idx          = owner;
          req_ready[owner] = req_valid[owner];
        end
        default: req_ready = '0;
      endcase
    end
  end

  assign xfer      = |(req_valid & req_ready);
  assign fsm_state = (state == LOCKED);

  // Pointer and lock owner only move on IDLE transfers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last  <= IDX_W'(NUM_REQ - 1);
      owner <= '0;
    end else if (state == IDLE && xfer) begin
      last <= sel_idx;
      if (req_lock[sel_idx]) owner <= sel_idx;
    end
  end

  // Strobe decode; out-of-range addresses strobe nothing.
  assign sel_addr = addr_arr[sel_idx];

  always_comb begin
    load_n_next = '1;
    addr_ok     = (32'(sel_addr) < 32'(NUM_REGS));
    for (int r = 0; r < NUM_REGS; r++) begin
      if (addr_ok && (sel_addr == ADDR_W'(r))) load_n_next[r] = 1'b0;
    end
  end

  // Registered write stage: a transfer at edge N is presented during cycle
  // N+1 and captured by the bank at edge N+1. reg_d holds when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_d      <= '0;
      reg_load_n <= '1;
      grant_id   <= '0;
      addr_err   <= 1'b0;
    end else if (xfer) begin
      reg_d      <= data_arr[sel_idx];
      reg_load_n <= load_n_next;
      grant_id   <= 3'(sel_idx);
      addr_err   <= !addr_ok;
    end else begin
      reg_load_n <= '1;
      addr_err   <= 1'b0;
    end
  end

  assign busy = (state == LOCKED) || (reg_load_n != '1);

endmodule

// File: tb/tb_regbank_write_arbiter.sv
module tb_regbank_write_arbiter;

  localparam logic [31:0] D0 = 32'h1000_00A0;
  localparam logic [31:0] D1 = 32'h1111_11A1;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h3333_33A3;
  localparam logic [127:0] DATA_ALL = {D3, D2, D1, D0};
  // req0 -> addr 0, req1 -> addr 1, req2 -> addr 5, req3 -> addr 3
  localparam logic [11:0] ADDR_ALL = {3'd3, 3'd5, 3'd1, 3'd0};

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_lock;
  logic [11:0]  req_addr;
  logic [127:0] req_data;

  logic [3:0]   req_ready;
  logic [31:0]  reg_d;
  logic [7:0]   reg_load_n;
  logic [2:0]   grant_id;
  logic         addr_err;
  logic         busy;
  logic         fsm_state;

  logic [3:0]   req_ready_6;
  logic [31:0]  reg_d_6;
  logic [5:0]   reg_load_n_6;
  logic [2:0]   grant_id_6;
  logic         addr_err_6;
  logic         busy_6;
  logic         fsm_state_6;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  regbank_write_arbiter #(.WIDTH(32), .NUM_REQ(4), .NUM_REGS(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .reg_d(reg_d), .reg_load_n(reg_load_n), .grant_id(grant_id),
    .addr_err(addr_err), .busy(busy), .fsm_state(fsm_state)
  );

  regbank_write_arbiter #(.WIDTH(32), .NUM_REQ(4), .NUM_REGS(6), .ADDR_W(3)) dut6 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready_6),
    .reg_d(reg_d_6), .reg_load_n(reg_load_n_6), .grant_id(grant_id_6),
    .addr_err(addr_err_6), .busy(busy_6), .fsm_state(fsm_state_6)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // Inputs applied for one cycle; ready is the combinational grant in that
  // cycle, the rest are the registered outputs from the previous edge.
  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  lock;
    logic [3:0]  ready;
    logic [7:0]  load_n;
    logic [31:0] d;
    logic [2:0]  gid;
    logic        busy;
    logic        state;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [3:0] r,
                              logic [7:0] ln, logic [31:0] d, logic [2:0] g,
                              logic b, logic s);
    vec_t t;
    t.valid = v; t.lock = l; t.ready = r; t.load_n = ln;
    t.d = d; t.gid = g; t.busy = b; t.state = s;
    return t;
  endfunction

  initial begin
    // round robin, all valid, from reset pointer (0 first)
    vecs[0]  = mk(4'b1111, 4'b0000, 4'b0001, 8'hFF, 32'h0, 3'd0, 1'b0, 1'b0);
    vecs[1]  = mk(4'b1111, 4'b0000, 4'b0010, 8'hFE, D0,    3'd0, 1'b1, 1'b0);
    vecs[2]  = mk(4'b1111, 4'b0000, 4'b0100, 8'hFD, D1,    3'd1, 1'b1, 1'b0);
    vecs[3]  = mk(4'b1111, 4'b0000, 4'b1000, 8'hDF, D2,    3'd2, 1'b1, 1'b0);
    vecs[4]  = mk(4'b1111, 4'b0000, 4'b0001, 8'hF7, D3,    3'd3, 1'b1, 1'b0);
    vecs[5]  = mk(4'b1111, 4'b0000, 4'b0010, 8'hFE, D0,    3'd0, 1'b1, 1'b0);
    vecs[6]  = mk(4'b1111, 4'b0000, 4'b0100, 8'hFD, D1,    3'd1, 1'b1, 1'b0);
    vecs[7]  = mk(4'b1111, 4'b0000, 4'b1000, 8'hDF, D2,    3'd2, 1'b1, 1'b0);
    vecs[8]  = mk(4'b0000, 4'b0000, 4'b0000, 8'hF7, D3,    3'd3, 1'b1, 1'b0);
    // requester 2 alone writes addr 5, 0xDEADBEEF
    vecs[9]  = mk(4'b0100, 4'b0000, 4'b0100, 8'hFF, D3,    3'd3, 1'b0, 1'b0);
    vecs[10] = mk(4'b0000, 4'b0000, 4'b0000, 8'hDF, D2,    3'd2, 1'b1, 1'b0);
    vecs[11] = mk(4'b0000, 4'b0000, 4'b0000, 8'hFF, D2,    3'd2, 1'b0, 1'b0);
    // req0 write to move pointer, then req1 locked burst of 4 with req0 waiting
    vecs[12] = mk(4'b0001, 4'b0000, 4'b0001, 8'hFF, D2,    3'd2, 1'b0, 1'b0);
    vecs[13] = mk(4'b0011, 4'b0010, 4'b0010, 8'hFE, D0,    3'd0, 1'b1, 1'b0);
    vecs[14] = mk(4'b0011, 4'b0010, 4'b0010, 8'hFD, D1,    3'd1, 1'b1, 1'b1);
    vecs[15] = mk(4'b0011, 4'b0010, 4'b0010, 8'hFD, D1,    3'd1, 1'b1, 1'b1);
    vecs[16] = mk(4'b0011, 4'b0000, 4'b0010, 8'hFD, D1,    3'd1, 1'b1, 1'b1);
    vecs[17] = mk(4'b0011, 4'b0000, 4'b0001, 8'hFD, D1,    3'd1, 1'b1, 1'b0);
    vecs[18] = mk(4'b0000, 4'b0000, 4'b0000, 8'hFE, D0,    3'd0, 1'b1, 1'b0);
    // req2 locks, then drops valid: no grant, back to IDLE, RR from 3
    vecs[19] = mk(4'b0100, 4'b0100, 4'b0100, 8'hFF, D0,    3'd0, 1'b0, 1'b0);
    vecs[20] = mk(4'b1011, 4'b0000, 4'b0000, 8'hDF, D2,    3'd2, 1'b1, 1'b1);
    vecs[21] = mk(4'b1011, 4'b0000, 4'b1000, 8'hFF, D2,    3'd2, 1'b0, 1'b0);
    vecs[22] = mk(4'b0000, 4'b0000, 4'b0000, 8'hF7, D3,    3'd3, 1'b1, 1'b0);
    vecs[23] = mk(4'b0000, 4'b0000, 4'b0000, 8'hFF, D3,    3'd3, 1'b0, 1'b0);
  end

  // ---------------- test ----------------
  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_addr  = ADDR_ALL;
    req_data  = DATA_ALL;

    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    check("reset ready",  32'(req_ready),  32'h0);
    check("reset load_n", 32'(reg_load_n), 32'hFF);
    check("reset d",      reg_d,           32'h0);
    check("reset gid",    32'(grant_id),   32'h0);
    check("reset err",    32'(addr_err),   32'h0);
    check("reset busy",   32'(busy),       32'h0);
    check("reset state",  32'(fsm_state),  32'h0);
    req_valid = '0;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      req_valid = vecs[i].valid;
      req_lock  = vecs[i].lock;
      #1;
      check($sformatf("v%0d ready", i),  32'(req_ready),  32'(vecs[i].ready));
      check($sformatf("v%0d load_n", i), 32'(reg_load_n), 32'(vecs[i].load_n));
      check($sformatf("v%0d d", i),      reg_d,           vecs[i].d);
      check($sformatf("v%0d gid", i),    32'(grant_id),   32'(vecs[i].gid));
      check($sformatf("v%0d busy", i),   32'(busy),       32'(vecs[i].busy));
      check($sformatf("v%0d state", i),  32'(fsm_state),  32'(vecs[i].state));
      check($sformatf("v%0d err", i),    32'(addr_err),   32'h0);
      @(posedge clk);
      #1;
    end

    // Address range: req3 writes 7, 6, 5; second instance has NUM_REGS = 6
    req_lock  = '0;
    req_valid = 4'b1000;
    req_addr[11:9] = 3'd7;
    #1;
    check("a7 ready",   32'(req_ready),   32'h8);
    check("a7 ready6",  32'(req_ready_6), 32'h8);
    @(posedge clk);
    #1;
    req_addr[11:9] = 3'd6;
    #1;
    check("a7 load_n8", 32'(reg_load_n),   32'h7F);
    check("a7 err8",    32'(addr_err),     32'h0);
    check("a7 load_n6", 32'(reg_load_n_6), 32'h3F);
    check("a7 err6",    32'(addr_err_6),   32'h1);
    check("a7 gid6",    32'(grant_id_6),   32'h3);
    check("a7 busy6",   32'(busy_6),       32'h0);
    @(posedge clk);
    #1;
    req_addr[11:9] = 3'd5;
    #1;
    check("a6 load_n8", 32'(reg_load_n),   32'hBF);
    check("a6 load_n6", 32'(reg_load_n_6), 32'h3F);
    check("a6 err6",    32'(addr_err_6),   32'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    #1;
    check("a5 load_n8", 32'(reg_load_n),   32'hDF);
    check("a5 load_n6", 32'(reg_load_n_6), 32'h1F);
    check("a5 err6",    32'(addr_err_6),   32'h0);
    check("a5 d6",      reg_d_6,           D3);
    @(posedge clk);
    #1;
    #1;
    check("idle err6",    32'(addr_err_6),   32'h0);
    check("idle load_n6", 32'(reg_load_n_6), 32'h3F);

    // Reset mid-operation: locked transfer, then async reset while strobing
    req_addr  = ADDR_ALL;
    req_valid = 4'b0001;
    req_lock  = 4'b0001;
    #1;
    check("rst ready pre", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    check("rst load_n pre", 32'(reg_load_n), 32'hFE);
    check("rst state pre",  32'(fsm_state),  32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("rst load_n async", 32'(reg_load_n), 32'hFF);
    check("rst ready async",  32'(req_ready),  32'h0);
    check("rst state async",  32'(fsm_state),  32'h0);
    check("rst busy async",   32'(busy),       32'h0);
    check("rst d async",      reg_d,           32'h0);
    @(posedge clk);
    #1;
    check("rst ready held",  32'(req_ready),  32'h0);
    check("rst load_n held", 32'(reg_load_n), 32'hFF);
    #3;
    reset = 1'b1;
    req_lock = '0;
    #1;
    check("post rst ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    check("post rst load_n", 32'(reg_load_n), 32'hFE);
    check("post rst gid",    32'(grant_id),   32'h0);
    check("post rst d",      reg_d,           D0);
    check("post rst ready2", 32'(req_ready),  32'h2);
    req_valid = '0;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares one bank of NUM_REGS `register` instances between NUM_REQ write requesters, e.g. the host bridge, the command processor and the rasteriser setup engine.
- Arbitrates round-robin, with an optional lock for bursts.
- Drives the bank's shared D bus and the per-register active-low load strobes.
- One write is retired per clock, with one cycle of registered latency.

Parameters:
- WIDTH, 32, data width of each register in the bank.
- NUM_REQ, 4, number of requesters (2..8).
- NUM_REGS, 8, number of registers in the bank.
- ADDR_W, 3, register address width. Must satisfy 2^ADDR_W >= NUM_REGS.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_lock  in  NUM_REQ  requester asks to keep the grant after this transfer.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs on any edge where req_valid[i] and req_ready[i] are both 1.
- reg_d  out  WIDTH  shared D bus to every register in the bank.
- reg_load_n  out  NUM_REGS  active-low load strobe, one per register.
- grant_id  out  3  index of the requester whose write is on reg_d this cycle.
- addr_err  out  1  one-cycle pulse for an accepted write whose address is >= NUM_REGS.
- busy  out  1  high while in LOCKED state or while a write strobe is active.

Behaviour:
Reset (reset = 0, asynchronous):
- reg_load_n = all ones; reg_d = 0; grant_id = 0; addr_err = 0; busy = 0.
- FSM = IDLE; round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
- req_ready = 0 for the whole time reset is low.

FSM states IDLE and LOCKED:
- IDLE:
  - req_ready is a combinational one-hot: the first i with req_valid[i]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - On a transfer by requester i: last <= i.
  - If req_lock[i] = 1 at that transfer: owner <= i and go to LOCKED.
- LOCKED:
  - req_ready[owner] = req_valid[owner]; every other bit of req_ready is 0.
  - Leave to IDLE on a transfer with req_lock[owner] = 0.
  - Leave to IDLE on any cycle where req_valid[owner] = 0; that cycle grants nobody.
  - last is not updated while in LOCKED.
- Idle / no request: no valid requests means req_ready = 0 and the state and pointer are unchanged.

Write stage (registered):
- A transfer from requester i at edge N drives the following during cycle N+1:
  - reg_d = req_data slice i;
  - reg_load_n[addr] = 0 and every other bit = 1;
  - grant_id = i.
- The bank register captures at edge N+1. Write latency is request-to-Q = 2 edges.
- Back-to-back transfers give continuous strobes, one register per cycle. Throughput is 1 per clock.
- A cycle with no transfer drives reg_load_n = all ones; reg_d holds its previous value.

Address error (addr >= NUM_REGS):
- The transfer is still accepted.
- In the following cycle reg_load_n = all ones and addr_err = 1 for exactly 1 cycle.
- grant_id still shows i.

busy:
- Equals (state == LOCKED) | (reg_load_n != all ones).

Reset asserted mid-operation:
- A pending strobe is dropped immediately (reg_load_n = all ones) and the lock is released.
- A transfer is never half-completed: the write either reached the bank at an edge before reset fell, or it did not happen.

Stable inputs:
- Requesters must hold addr and data stable while valid=1 and ready=0.
- The arbiter never withdraws req_ready within a cycle unless req_valid changes.

Test Plan:
1. Reset, then requester 2 writes addr 5, data 0xDEADBEEF:
   - req_ready = 0100 in that cycle.
   - Next cycle: reg_load_n = 8'b1101_1111, reg_d = 0xDEADBEEF, grant_id = 2.
   - Following cycle: reg_load_n = 8'hFF.
2. All 4 requesters hold valid, no lock, for 8 cycles:
   - Grants come in order 0, 1, 2, 3, 0, 1, 2, 3.
   - Each requester's data appears on reg_d one cycle after its grant.
   - reg_load_n goes low in every one of the 8 cycles after the first.
3. Requester 1 has lock=1 for 3 transfers, then lock=0 on the 4th, while requester 0 is valid throughout:
   - req_ready[0] = 0 for all 4 transfers; busy = 1.
   - Requester 0 is granted on the cycle after the unlocked transfer.
4. Requester 3 writes addr 7 (valid), then addr 6 with NUM_REGS = 6:
   - First write: reg_load_n[7] is NOT asserted, because addr 7 >= NUM_REGS and this is an error.
   - Rerun with NUM_REGS = 8 and addr 7: strobe on bit 7, addr_err = 0.
   - With NUM_REGS = 6 and addr 6: addr_err = 1 for one cycle, reg_load_n = all ones.
5. Reset pulled low in the cycle after a transfer:
   - reg_load_n returns to all ones asynchronously; req_ready = 0; the FSM leaves LOCKED.
   - After reset rises, requester 0 wins first.
6. Locked owner drops valid for one cycle:
   - The FSM returns to IDLE that cycle with no grant.
   - The next cycle arbitrates round-robin from last+1.
